// File: rtl/raybox_buttons.sv
// Four-button front end: synchronizes and debounces K4..K1, then decodes
// movement or debug levels, with chord modes reached by opposing presses.
module raybox_buttons #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:1] K_n,
  output logic       moveF,
  output logic       moveB,
  output logic       moveL,
  output logic       moveR,
  output logic       debugA,
  output logic       debugB,
  output logic       debugC,
  output logic       debugD,
  output logic [1:0] chord
);

  // state  | meaning
  // NORMAL | plain movement decode
  // CHORD1 | K2+K3 held; K4/K1 drive debugA/debugB
  // CHORD2 | K1+K4 held; K2/K3 drive debugC/debugD
  // DRAIN  | chord broken; outputs quiet until every button is released
  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    CHORD1 = 2'd1,
    CHORD2 = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [4:1]    sync1_q, sync2_q;
  logic [4:1]    stable_q;
  logic [CW-1:0] cnt_q [4:1];
  logic [4:1]    pressed;
  state_t        state_q, state_d;
  logic [7:0]    out_d, out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= K_n;
      sync2_q <= sync1_q;
    end
  end

  // A single matching sample clears the count, so bounces restart it and it
  // can never reach past DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 4'hF;
      for (int i = 1; i <= 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 1; i <= 4; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= ~stable_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign pressed = ~stable_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL: begin
        if (pressed[2] && pressed[3])      state_d = CHORD1;
        else if (pressed[1] && pressed[4]) state_d = CHORD2;
      end
      CHORD1: if (!(pressed[2] && pressed[3])) state_d = DRAIN;
      CHORD2: if (!(pressed[1] && pressed[4])) state_d = DRAIN;
      DRAIN:  if (pressed == 4'b0000)          state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // Outputs follow the next state so a mode change and its decode land together.
  // Bit order: {moveF, moveB, moveL, moveR, debugA, debugB, debugC, debugD}
  always_comb begin
    out_d = 8'h00;
    case (state_d)
      NORMAL:  out_d[7:4] = {pressed[4], pressed[1], pressed[3], pressed[2]};
      CHORD1:  out_d[3:2] = {pressed[4], pressed[1]};
      CHORD2:  out_d[1:0] = {pressed[2], pressed[3]};
      default: out_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= NORMAL;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign {moveF, moveB, moveL, moveR, debugA, debugB, debugC, debugD} = out_q;
  assign chord = state_q;

endmodule

// File: tb/tb_raybox_buttons.sv
// Directed bench for raybox_buttons with DEBOUNCE_CYCLES = 4 (edge-to-output latency 7).
module tb_raybox_buttons;

  localparam int LAT = 7;

  logic       clk;
  logic       reset_n;
  logic [4:1] K_n;
  logic       moveF, moveB, moveL, moveR;
  logic       debugA, debugB, debugC, debugD;
  logic [1:0] chord;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  raybox_buttons #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .K_n(K_n),
    .moveF(moveF), .moveB(moveB), .moveL(moveL), .moveR(moveR),
    .debugA(debugA), .debugB(debugB), .debugC(debugC), .debugD(debugD),
    .chord(chord)
  );

  assign outs = {moveF, moveB, moveL, moveR, debugA, debugB, debugC, debugD};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:1] v);
    @(negedge clk);
    K_n = v;
  endtask

  task automatic release_all();
    drive(4'hF);
    repeat (12) tick();
    checks++;
    if (outs !== 8'h00 || chord !== 2'd0) begin
      errors++;
      $display("FAIL idle: outs=%h chord=%0d expected outs=00 chord=0", outs, chord);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    K_n = 4'hF;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outs !== 8'h00 || chord !== 2'd0) begin
      errors++;
      $display("FAIL reset: outs=%h chord=%0d expected 00/0", outs, chord);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (outs !== 8'h00 || chord !== 2'd0) begin
      errors++;
      $display("FAIL post_reset: outs=%h chord=%0d expected 00/0", outs, chord);
    end
  endtask

  task automatic test_press_release();
    drive(4'b0111);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (moveF !== (k >= LAT)) begin
        errors++;
        $display("FAIL moveF_rise cyc%0d: got %b expected %b", k, moveF, (k >= LAT));
      end
    end
    checks++;
    if (outs !== 8'b1000_0000) begin
      errors++;
      $display("FAIL moveF_only: outs=%b expected 10000000", outs);
    end
    drive(4'hF);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (moveF !== (k < LAT)) begin
        errors++;
        $display("FAIL moveF_fall cyc%0d: got %b expected %b", k, moveF, (k < LAT));
      end
    end
  endtask

  task automatic test_bounce();
    drive(4'b1110);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (moveB !== 1'b0) begin
        errors++;
        $display("FAIL bounce_low cyc%0d: moveB=%b expected 0", k, moveB);
      end
    end
    drive(4'hF);
    tick();
    checks++;
    if (moveB !== 1'b0) begin
      errors++;
      $display("FAIL bounce_high: moveB=%b expected 0", moveB);
    end
    drive(4'b1110);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (moveB !== (k >= LAT)) begin
        errors++;
        $display("FAIL bounce_final cyc%0d: moveB=%b expected %b", k, moveB, (k >= LAT));
      end
    end
    release_all();
  endtask

  task automatic test_chord1();
    drive(4'b1001);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (moveL !== 1'b0 || moveR !== 1'b0 || chord !== ((k >= LAT) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("FAIL chord1_enter cyc%0d: L=%b R=%b chord=%0d expected L=0 R=0 chord=%0d",
                 k, moveL, moveR, chord, (k >= LAT) ? 1 : 0);
      end
    end
    drive(4'b0001);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (moveL !== 1'b0 || moveR !== 1'b0 || chord !== 2'd1 || debugA !== (k >= LAT)) begin
        errors++;
        $display("FAIL chord1_debugA cyc%0d: L=%b R=%b chord=%0d A=%b expected 0 0 1 %b",
                 k, moveL, moveR, chord, debugA, (k >= LAT));
      end
    end
    drive(4'b0101);
    repeat (LAT) tick();
    checks++;
    if (chord !== 2'd3 || outs !== 8'h00) begin
      errors++;
      $display("FAIL chord1_drain: chord=%0d outs=%h expected 3/00", chord, outs);
    end
    drive(4'hF);
    repeat (LAT) tick();
    checks++;
    if (chord !== 2'd0 || outs !== 8'h00) begin
      errors++;
      $display("FAIL chord1_exit: chord=%0d outs=%h expected 0/00", chord, outs);
    end
  endtask

  task automatic test_all_four();
    drive(4'b0000);
    repeat (LAT) tick();
    checks++;
    if (chord !== 2'd1 || outs !== 8'b0000_1100) begin
      errors++;
      $display("FAIL all_four: chord=%0d outs=%b expected 1/00001100", chord, outs);
    end
    release_all();
  endtask

  task automatic test_reset_in_chord();
    drive(4'b0110);
    repeat (LAT) tick();
    checks++;
    if (chord !== 2'd2 || outs !== 8'h00) begin
      errors++;
      $display("FAIL chord2_enter: chord=%0d outs=%h expected 2/00", chord, outs);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (chord !== 2'd0 || outs !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: chord=%0d outs=%h expected 0/00", chord, outs);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (chord !== ((k >= LAT) ? 2'd2 : 2'd0) || outs !== 8'h00) begin
        errors++;
        $display("FAIL chord2_reentry cyc%0d: chord=%0d outs=%h expected %0d/00",
                 k, chord, outs, (k >= LAT) ? 2 : 0);
      end
    end
    release_all();
  endtask

  task automatic test_move_to_chord();
    drive(4'b1101);
    for (int k = 1; k < 20; k++) begin
      tick();
      checks++;
      if (moveR !== (k >= LAT) || moveL !== 1'b0) begin
        errors++;
        $display("FAIL moveR_alone cyc%0d: R=%b L=%b expected %b 0", k, moveR, moveL, (k >= LAT));
      end
    end
    drive(4'b1001);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (moveR !== (k < LAT) || moveL !== 1'b0 || chord !== ((k >= LAT) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("FAIL moveR_to_chord cyc%0d: R=%b L=%b chord=%0d expected %b 0 %0d",
                 k, moveR, moveL, chord, (k < LAT), (k >= LAT) ? 1 : 0);
      end
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_chord1();
    test_all_four();
    test_reset_in_chord();
    test_move_to_chord();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raybox_buttons.md
RAYBOX_BUTTONS -- requirements
Module: raybox_buttons

Interface
REQ-001 Parameter DEBOUNCE_CYCLES SHALL default to 250000 (10 ms at 25 MHz) and is the number of consecutive cycles an input must differ before it is accepted; legal range is 1 to 2^20.
REQ-002 clk  input  1  single design clock, 25 MHz pixel clock; all state SHALL be on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 K_n  input  4  raw external buttons K4..K1, active-low, asynchronous to clk; index 4 is the top button and index 1 is the bottom button.
REQ-005 moveF, moveB, moveL, moveR  output  1 each  registered active-high movement levels.
REQ-006 debugA, debugB, debugC, debugD  output  1 each  registered active-high debug levels.
REQ-007 chord  output  2  registered mode indicator: 0 = NORMAL, 1 = CHORD1, 2 = CHORD2, 3 = DRAIN.

Function
REQ-008 Each K_n bit SHALL pass through a 2-flop synchronizer; both flops reset to 1 (released).
REQ-009 Each button SHALL have its own stable state and counter, width clog2(DEBOUNCE_CYCLES+1).
REQ-010 When the synchronized bit equals its stable state, the counter SHALL clear to 0.
REQ-011 When the synchronized bit differs from its stable state, the counter SHALL increment, and the stable state SHALL toggle on the cycle the counter would reach DEBOUNCE_CYCLES; the counter then clears.
REQ-012 A bounce (any single matching sample) SHALL restart the count; the counter SHALL never wrap.
REQ-013 pressed[i] SHALL be the inverse of stable[i].
REQ-014 The FSM SHALL have states NORMAL, CHORD1, CHORD2 and DRAIN.
REQ-015 From NORMAL, the FSM SHALL go to CHORD1 if pressed[2] and pressed[3]; else to CHORD2 if pressed[1] and pressed[4]; else stay in NORMAL. CHORD1 has priority when all four buttons are pressed.
REQ-016 From CHORD1, the FSM SHALL go to DRAIN when pressed[2] and pressed[3] are no longer both true.
REQ-017 From CHORD2, the FSM SHALL go to DRAIN when pressed[1] and pressed[4] are no longer both true.
REQ-018 From DRAIN, the FSM SHALL go to NORMAL only when no button is pressed; otherwise it stays in DRAIN.
REQ-019 All outputs SHALL be registered and decoded from the next state and the current pressed vector, so no output ever reflects a stale state.
REQ-020 In NORMAL, the move outputs SHALL be: moveF = pressed[4], moveB = pressed[1], moveL = pressed[3], moveR = pressed[2]; all debug outputs are 0.
REQ-021 In CHORD1, debugA SHALL equal pressed[4] and debugB SHALL equal pressed[1]; all other move and debug outputs are 0.
REQ-022 In CHORD2, debugC SHALL equal pressed[2] and debugD SHALL equal pressed[3]; all other move and debug outputs are 0.
REQ-023 In DRAIN, all move and debug outputs SHALL be 0, so partial chord release never produces a move.
REQ-024 Latency from a clean raw edge to an output change SHALL be exactly DEBOUNCE_CYCLES+3 clk cycles: 2 synchronizer cycles, DEBOUNCE_CYCLES debounce cycles, and 1 output register cycle.
REQ-025 Simultaneous stable changes on several buttons in one cycle SHALL be evaluated together in a single FSM step.
REQ-026 Opposing moves (F with B, or L with R) SHALL never both be asserted, because those combinations enter a chord state instead.

Reset
REQ-027 While reset_n is low, the synchronizers, stable states and counters SHALL hold released/0, the FSM SHALL be in NORMAL, all move and debug outputs SHALL be 0, and chord SHALL be 0.
REQ-028 Reset assertion SHALL take effect asynchronously.
REQ-029 Reset deassertion SHALL be treated as synchronous to clk by the integrator; the block itself contains no reset synchronizer.
REQ-030 Reset asserted mid-debounce or mid-chord SHALL discard all progress.
REQ-031 Buttons held through reset release SHALL be accepted only after a full debounce from release.

Verification (DEBOUNCE_CYCLES = 4)
REQ-032 Press K_n[4] cleanly at cycle 0 -> moveF rises at cycle 7; release it -> moveF falls 7 cycles after release.
REQ-033 K_n[1] bounces low for 3 cycles, high for 1 cycle, then stays low -> moveB rises 7 cycles after the final low edge, and shows no glitch before that.
REQ-034 Press K2 and K3 together, then K4 -> chord = 1, moveL and moveR stay 0 throughout, and debugA = 1; release only K3 -> chord = 3 and all outputs are 0; release all -> chord = 0.
REQ-035 Press all four buttons simultaneously -> chord = 1 (priority rule), debugA = 1, debugB = 1, and debugC and debugD stay 0.
REQ-036 Press K1 and K4 to enter chord = 2, then pulse reset_n low for 1 cycle with all buttons still held -> all outputs are 0 immediately; after release, chord returns to 2 at DEBOUNCE_CYCLES+3 cycles.
REQ-037 Press K2 alone, then add K3 after 20 cycles -> moveR is 1, then drops to 0 on the same cycle that chord becomes 1, and moveL is never asserted.
